intersection_scheduler: RTL and testbench

Sequences the two traffic-light approaches of the intersection so they can never show conflicting aspects. It also inserts an optional pedestrian all-red phase and produces per-approach light, countdown and matrix-pattern outputs for the seven-segment and LED-matrix drivers. It runs on the fast system clock, advances only on a 1 Hz `tick` strobe from the frequency divider, and replaces the two free-running light/counter pairs.

---
 rtl/intersection_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_intersection_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Purpose  : Sequences the two approaches of an intersection so they never
//            show conflicting aspects, with an optional pedestrian all-red
//            walk phase. Advances only on the 1 Hz tick strobe and decodes
//            light, countdown and matrix-pattern outputs from registered state.
// Config   : define PED_PHASE_EN to build the pedestrian request/walk logic.
//            Without it pedReq is ignored and the cycle is fixed.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset
//            tick     - one-clk 1 Hz enable strobe
//            pedReq   - pedestrian request, any width
//            light0/1 - one-hot {red, yellow, green} per approach
//            count0/1 - seconds until the approach's light changes
//            pattern0/1 - 0 stop, 1 caution, 2 go, 3 walk
//            phase    - current state encoding (debug)
// Revision : 1.0  initial release
// ============================================================================
module intersection_scheduler #(
  parameter int unsigned GREEN_T  = 9,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned PED_T    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pedReq,
  output logic [2:0] light0,
  output logic [2:0] light1,
  output logic [5:0] count0,
  output logic [5:0] count1,
  output logic [1:0] pattern0,
  output logic [1:0] pattern1,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_G0  = 3'd0,
    ST_Y0  = 3'd1,
    ST_AR0 = 3'd2,
    ST_G1  = 3'd3,
    ST_Y1  = 3'd4,
    ST_AR1 = 3'd5,
    ST_PED = 3'd6
  } state_t;

  localparam logic [5:0] c_green_t  = 6'(GREEN_T);
  localparam logic [5:0] c_yellow_t = 6'(YELLOW_T);
  localparam logic [5:0] c_allred_t = 6'(ALLRED_T);

  localparam logic [2:0] c_red    = 3'b100;
  localparam logic [2:0] c_yellow = 3'b010;
  localparam logic [2:0] c_green  = 3'b001;

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [5:0] w_ped_extra;
  logic [5:0] w_timer6;

  function automatic logic [3:0] dur(input state_t s);
    case (s)
      ST_G0, ST_G1:   dur = 4'(GREEN_T);
      ST_Y0, ST_Y1:   dur = 4'(YELLOW_T);
      ST_AR0, ST_AR1: dur = 4'(ALLRED_T);
      default:        dur = 4'(PED_T);
    endcase
  endfunction

`ifdef PED_PHASE_EN
  localparam logic [5:0] c_ped_t = 6'(PED_T);
  logic ped_pend_q, ped_pend_d;
  logic next_road_q, next_road_d;  // 1: G1 follows the walk, 0: G0 follows
  assign w_ped_extra = ped_pend_q ? c_ped_t : 6'd0;
`else
  logic unused_cfg;
  assign unused_cfg  = pedReq ^ (PED_T != 0);
  assign w_ped_extra = 6'd0;
`endif

  // Next state / timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
`ifdef PED_PHASE_EN
    ped_pend_d  = ped_pend_q | pedReq;
    next_road_d = next_road_q;
`endif
    if (tick) begin
      if (timer_q == 4'd1) begin
        case (state_q)
          ST_G0:  state_d = ST_Y0;
          ST_Y0:  state_d = ST_AR0;
          ST_AR0: begin
            state_d = ST_G1;
`ifdef PED_PHASE_EN
            if (ped_pend_q) begin
              state_d     = ST_PED;
              next_road_d = 1'b1;
            end
`endif
          end
          ST_G1:  state_d = ST_Y1;
          ST_Y1:  state_d = ST_AR1;
          ST_AR1: begin
            state_d = ST_G0;
`ifdef PED_PHASE_EN
            if (ped_pend_q) begin
              state_d     = ST_PED;
              next_road_d = 1'b0;
            end
`endif
          end
`ifdef PED_PHASE_EN
          ST_PED: state_d = next_road_q ? ST_G1 : ST_G0;
`endif
          default: state_d = ST_G0;
        endcase
        timer_d = dur(state_d);
`ifdef PED_PHASE_EN
        // Entering the walk services the pending request; a request on this
        // very cycle is kept for the next all-red.
        if (state_d == ST_PED) ped_pend_d = pedReq;
`endif
      end else begin
        timer_d = timer_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_G0;
      timer_q <= 4'(GREEN_T);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

`ifdef PED_PHASE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_q  <= 1'b0;
      next_road_q <= 1'b0;
    end else begin
      ped_pend_q  <= ped_pend_d;
      next_road_q <= next_road_d;
    end
  end
`endif

  assign w_timer6 = {2'b00, timer_q};
  assign phase    = state_q;

  // Output decode: registered state, timer and pending flag only
  always_comb begin
    light0   = c_red;
    light1   = c_red;
    pattern0 = 2'd0;
    pattern1 = 2'd0;
    count0   = 6'd0;
    count1   = 6'd0;
    case (state_q)
      ST_G0: begin
        light0   = c_green;
        pattern0 = 2'd2;
        count0   = w_timer6;
        count1   = w_timer6 + c_yellow_t + c_allred_t + w_ped_extra;
      end
      ST_Y0: begin
        light0   = c_yellow;
        pattern0 = 2'd1;
        count0   = w_timer6;
        count1   = w_timer6 + c_allred_t + w_ped_extra;
      end
      ST_AR0: count1 = w_timer6 + w_ped_extra;
      ST_G1: begin
        light1   = c_green;
        pattern1 = 2'd2;
        count1   = w_timer6;
        count0   = w_timer6 + c_yellow_t + c_allred_t + w_ped_extra;
      end
      ST_Y1: begin
        light1   = c_yellow;
        pattern1 = 2'd1;
        count1   = w_timer6;
        count0   = w_timer6 + c_allred_t + w_ped_extra;
      end
      ST_AR1: count0 = w_timer6 + w_ped_extra;
`ifdef PED_PHASE_EN
      ST_PED: begin
        pattern0 = 2'd3;
        pattern1 = 2'd3;
        // Only the road whose green follows the walk counts down.
        if (next_road_q) count1 = w_timer6;
        else             count0 = w_timer6;
      end
`endif
      default: ;
    endcase
  end

  // c_green_t documents the reset countdown base alongside the others
  logic unused_green;
  assign unused_green = |c_green_t;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_scheduler
// Purpose  : Self-checking bench for intersection_scheduler. A behavioural
//            model predicts the outputs for every clock; predictions are
//            queued when stimulus is driven and popped when the DUT output
//            is sampled. Pedestrian scenarios run when PED_PHASE_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module tb_intersection_scheduler;

`ifdef PED_PHASE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       pedReq = 1'b0;
  logic [2:0] light0, light1, phase;
  logic [5:0] count0, count1;
  logic [1:0] pattern0, pattern1;

  intersection_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .pedReq(pedReq),
    .light0(light0), .light1(light1),
    .count0(count0), .count1(count1),
    .pattern0(pattern0), .pattern1(pattern1),
    .phase(phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // states: 0 G0, 1 Y0, 2 AR0, 3 G1, 4 Y1, 5 AR1, 6 PED
  int m_st, m_tmr;
  bit m_pend, m_next;  // m_next: 1 -> G1 after walk

  function automatic int dur(input int s);
    case (s)
      0, 3:    return 9;
      1, 4:    return 3;
      2, 5:    return 1;
      default: return 5;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit t, input bit q);
    bit np;
    int ns;
    if (r) begin
      m_st = 0; m_tmr = 9; m_pend = 0; m_next = 0;
      return;
    end
    np = m_pend | (PED_EN & q);
    if (t) begin
      if (m_tmr == 1) begin
        case (m_st)
          2:       begin ns = m_pend ? 6 : 3; if (m_pend) m_next = 1; end
          5:       begin ns = m_pend ? 6 : 0; if (m_pend) m_next = 0; end
          6:       ns = m_next ? 3 : 0;
          default: ns = m_st + 1;
        endcase
        if (ns == 6) np = PED_EN & q;
        m_st = ns;
        m_tmr = dur(ns);
      end else begin
        m_tmr--;
      end
    end
    m_pend = np;
  endtask

  // Walks the phase sequence forward until the next green appears.
  function automatic logic [5:0] model_count(input int r);
    int g, y, s, sum, ns, nxt;
    bit p;
    g = r ? 3 : 0;
    y = r ? 4 : 1;
    if (m_st == g || m_st == y) return 6'(m_tmr);
    sum = m_tmr; s = m_st; p = m_pend; nxt = m_next ? 3 : 0;
    for (int k = 0; k < 8; k++) begin
      case (s)
        2:       begin ns = p ? 6 : 3; nxt = 3; end
        5:       begin ns = p ? 6 : 0; nxt = 0; end
        6:       ns = nxt;
        default: ns = s + 1;
      endcase
      if (ns == 0 || ns == 3) return (ns == g) ? 6'(sum) : 6'd0;
      if (ns == 6) p = 0;
      sum += dur(ns);
      s = ns;
    end
    return 6'd0;
  endfunction

  function automatic logic [2:0] model_light(input int r);
    if (m_st == (r ? 3 : 0)) return 3'b001;
    if (m_st == (r ? 4 : 1)) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [1:0] model_pat(input int r);
    logic [2:0] l;
    if (m_st == 6) return 2'd3;
    l = model_light(r);
    return l[0] ? 2'd2 : (l[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [24:0] model_vec();
    return {3'(m_st), model_light(0), model_light(1), model_count(0),
            model_count(1), model_pat(0), model_pat(1)};
  endfunction

  logic [24:0] sb[$];
  int cyc = 0;

  task automatic step(input bit r, input bit t, input bit q);
    logic [24:0] exp;
    rst = r; tick = t; pedReq = q;
    @(posedge clk);
    model_step(r, t, q);
    sb.push_back(model_vec());
    #1;
    cyc++;
    exp = sb.pop_front();
    check($sformatf("outs@%0d", cyc),
          32'({phase, light0, light1, count0, count1, pattern0, pattern1}), 32'(exp));
    check("no_conflict", 32'((light0 != 3'b100) && (light1 != 3'b100)), 32'd0);
  endtask

  task automatic do_tick(input bit q);
    step(0, 1, q);
    step(0, 0, q);
    step(0, 0, q);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_light0"}, 32'(light0), 32'h1);
    check({tag, "_light1"}, 32'(light1), 32'h4);
    check({tag, "_count0"}, 32'(count0), 32'd9);
    check({tag, "_count1"}, 32'(count1), 32'd13);
    check({tag, "_pat0"}, 32'(pattern0), 32'd2);
    check({tag, "_pat1"}, 32'(pattern1), 32'd0);
    check({tag, "_phase"}, 32'(phase), 32'd0);
  endtask

  initial begin
    int guard;
    // Reset and idle without ticks
    step(1, 0, 0);
    step(1, 0, 0);
    check_reset_values("rst");
    repeat (100) step(0, 0, 0);
    check_reset_values("idle");

    // One full cycle with no request
    repeat (26) do_tick(0);
    check("wrap_phase", 32'(phase), 32'd0);
    check("wrap_count0", 32'(count0), 32'd9);

`ifdef PED_PHASE_EN
    // Short request during G0, then a walk after AR0
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    check("ped_count1", 32'(count1), 32'd18);
    guard = 0;
    while (m_st != 6 && guard < 40) begin do_tick(0); guard++; end
    check("ped_reached", 32'(phase), 32'd6);
    // Request during the walk: serviced at the following all-red
    step(0, 0, 1);
    repeat (50) do_tick(0);
`endif

    // pedReq held high for 60 ticks
    repeat (60) begin
      do_tick(1);
`ifndef PED_PHASE_EN
      check("no_walk", 32'((pattern0 == 2'd3) || (pattern1 == 2'd3)), 32'd0);
`endif
    end

    // Reset mid-Y1 coincident with tick and request
    guard = 0;
    while (!(m_st == 4 && m_tmr == 2) && guard < 80) begin do_tick(0); guard++; end
    check("reach_y1", 32'(phase), 32'd4);
    step(1, 1, 1);
    check_reset_values("midrst");
    repeat (10) do_tick(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
